// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and defaults for the matrix FIFO and its push arbiter.
package fifo_pkg;
  localparam int DATA_W = 16;
  typedef logic [DATA_W-1:0] data_t;
  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_ROW_LEN = 8;
  typedef enum logic {IDLE, BURST} arb_state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: producer-side request bus plus the fifo_matrix push port.
interface fifo_push_arbiter_if
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ
);
  logic [NUM_REQ-1:0]         req;
  data_t [NUM_REQ-1:0]        req_data;
  logic                       full;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         ack;
  logic                       push;
  data_t                      data_in;
  logic                       busy;
  modport master (input req, req_data, full, output grant, ack, push, data_in, busy);
  modport slave (output req, req_data, full, input grant, ack, push, data_in, busy);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: picks the first asserted request at or after ptr, wrapping to index 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[(int'(ptr) + i) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + i) % N);
        gnt[(int'(ptr) + i) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst-locked sharing of the fifo_matrix push port.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr_ptr).
module fifo_push_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ROW_LEN = ARB_ROW_LEN
) (
  input logic               clk,
  input logic               rst,
  fifo_push_arbiter_if.master bus
);
  localparam int IW = clog2_min1(NUM_REQ);
  localparam int BW = clog2_min1(ROW_LEN);
  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick_gnt;
  logic [IW-1:0]      owner_q, owner_d, pick_idx, pick_ptr;
  logic [BW-1:0]      beat_q, beat_d;
  logic               pick_valid, accept, last;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_nxt;
  assign owner_nxt = owner_q == IW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
  assign rr_ptr_d  = accept && last ? owner_nxt : rr_ptr_q;
  assign pick_ptr  = rr_ptr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
`endif

  // A beat only moves while the owner still requests and the FIFO has room.
  assign accept = state_q == BURST && bus.req[owner_q] && !bus.full;
  assign last   = beat_q == BW'(ROW_LEN - 1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    if (state_q == IDLE && pick_valid) begin
      state_d = BURST;
      grant_d = pick_gnt;
      owner_d = pick_idx;
      beat_d  = '0;
    end
    if (accept) begin
      beat_d  = last ? '0 : beat_q + 1'b1;
      state_d = last ? IDLE : BURST;
      grant_d = last ? '0 : grant_q;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end

  assign bus.grant   = grant_q;
  assign bus.push    = accept;
  assign bus.ack     = accept ? grant_q : '0;
  assign bus.data_in = accept ? bus.req_data[owner_q] : '0;
  assign bus.busy    = state_q == BURST;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed checks of arbitration, burst lock, backpressure and reset.
module tb_fifo_push_arbiter;
  import fifo_pkg::*;
  logic clk, rst;
  logic [3:0] base_req;
  int checks = 0;
  int errors = 0;
  int pcnt [4] = '{0, 0, 0, 0};
  int exp_next [4] = '{0, 0, 0, 0};

  fifo_push_arbiter_if #(.NUM_REQ(4)) bus ();

  fifo_push_arbiter #(.NUM_REQ(4), .ROW_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Each producer offers 0x1000*(i+1) + words-already-acked.
  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (bus.ack[i]) pcnt[i] <= pcnt[i] + 1;

  always_comb
    for (int i = 0; i < 4; i++) bus.req_data[i] = data_t'(32'h1000 * (i + 1) + pcnt[i]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle_check();
    check("idle_grant", 32'(bus.grant), 0);
    check("idle_busy", 32'(bus.busy), 0);
  endtask

  // Called at posedge+1 of the first granted cycle; returns at posedge+1 after the last counted push.
  task automatic burst(input int own, input int n_push, input int f_at, input int f_len,
                       input int d_at, input int d_len);
    int n = 0;
    int cyc = 0;
    int fl = f_len;
    int dl = d_len;
    logic ep;
    while (n < n_push && cyc < 40) begin
      bus.req  = base_req;
      bus.full = 1'b0;
      if (n == f_at && fl > 0) begin bus.full = 1'b1; fl--; end
      if (n == d_at && dl > 0) begin bus.req[own] = 1'b0; dl--; end
      ep = !bus.full && bus.req[own];
      @(negedge clk);
      check("grant", 32'(bus.grant), 32'(1 << own));
      check("busy", 32'(bus.busy), 1);
      check("push", 32'(bus.push), 32'(ep));
      check("ack", 32'(bus.ack), ep ? 32'(1 << own) : 0);
      if (ep) begin
        check("data", 32'(bus.data_in), 32'h1000 * (own + 1) + exp_next[own]);
        exp_next[own]++;
        n++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    bus.req  = base_req;
    bus.full = 1'b0;
    check("pushes", n, n_push);
  endtask

  initial begin
    int own;
    rst = 1; base_req = 4'h0; bus.req = 4'h0; bus.full = 0;
    #2 rst = 0; base_req = 4'hf; bus.req = base_req;
    @(negedge clk);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_push", 32'(bus.push), 0);
    check("rst_data", 32'(bus.data_in), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk) rst = 1;
    @(posedge clk) #1;
    check("first_grant", 32'(bus.grant), 32'h1);
    check("first_busy", 32'(bus.busy), 1);
    rst = 0;
    #1;
    check("async_grant", 32'(bus.grant), 0);
    check("async_push", 32'(bus.push), 0);
    check("async_ack", 32'(bus.ack), 0);
    check("async_busy", 32'(bus.busy), 0);
    base_req = 4'h0; bus.req = base_req;
    @(negedge clk) rst = 1;

    @(posedge clk) #1;
    base_req = 4'b0100; bus.req = base_req;
    @(posedge clk) #1;
    burst(2, 8, -1, 0, -1, 0);
    base_req = 4'h0; bus.req = base_req;
    idle_check();

    rst = 0; #1 rst = 1;
    base_req = 4'hf; bus.req = base_req;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk) #1;
`ifdef FIFO_ARB_FIXED_PRIO_EN
      own = 0;
`else
      own = k % 4;
`endif
      burst(own, 8, -1, 0, -1, 0);
      if (k == 4) begin base_req = 4'h0; bus.req = base_req; end
      idle_check();
    end

    @(posedge clk) #1;
    base_req = 4'b1000; bus.req = base_req;
    @(posedge clk) #1;
    burst(3, 8, 3, 3, -1, 0);
    base_req = 4'h0; bus.req = base_req;
    idle_check();

    base_req = 4'b1010; bus.req = base_req;
    @(posedge clk) #1;
    burst(1, 8, -1, 0, 4, 2);
    idle_check();

    @(posedge clk) #1;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    own = 1;
`else
    own = 3;
`endif
    burst(own, 4, -1, 0, -1, 0);
    rst = 0;
    #1;
    check("mid_grant", 32'(bus.grant), 0);
    check("mid_push", 32'(bus.push), 0);
    check("mid_ack", 32'(bus.ack), 0);
    check("mid_busy", 32'(bus.busy), 0);
    rst = 1;
    @(posedge clk) #1;
    burst(1, 8, -1, 0, -1, 0);
    base_req = 4'h0; bus.req = base_req;
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
